// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver):
// payload width, frame length, receiver state encoding and parity helper.
package serial_pkg;

  localparam int DATA_W     = 7;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Parity bit that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: one sample_tick_o per serial bit, phased so the first
// tick after start_i lands mid start bit. With CLKS_PER_BIT=1 it ticks every cycle.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic sample_tick_o
);

  localparam int         HALF   = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);
  // Start detect already is the start sample when HALF is 0, so skip straight
  // to a full period; otherwise count down to the centre of the start bit.
  localparam logic [7:0] FIRST  = (HALF == 0) ? RELOAD : 8'(HALF - 1);

  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)             cnt_d = FIRST;
    else if (cnt_q == 8'd0)  cnt_d = RELOAD;
    else                     cnt_d = cnt_q - 8'd1;
  end

  assign sample_tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/serial_data_receiver.sv
// Serial frame receiver: start, DATA_W bits LSB first, even parity, stop.
// Optional SERIAL_RX_ERR_CNT_EN adds a saturating err_count output.
module serial_data_receiver #(
  parameter int DATA_W       = serial_pkg::DATA_W,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              busy,
  output logic [2:0]        state_dbg
`ifdef SERIAL_RX_ERR_CNT_EN
  ,output logic [7:0]       err_count
`endif
);

  import serial_pkg::*;

  localparam int   HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam bit   HALF_ZERO = (HALF == 0);
  localparam int   IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_error_q, parity_error_d;
  logic              framing_error_q, framing_error_d;
  logic              start_det;
  logic              tick;

  assign start_det = (state_q == RX_IDLE) && !serial_in;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_det),
    .sample_tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (!serial_in) state_d = HALF_ZERO ? RX_DATA : RX_START;
      RX_START:  if (tick) state_d = serial_in ? RX_IDLE : RX_DATA;
      RX_DATA:   if (tick && bit_idx_q == LAST_IDX) state_d = RX_PARITY;
      RX_PARITY: if (tick) state_d = RX_STOP;
      RX_STOP:   if (tick) state_d = serial_in ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (serial_in) state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  // Strobe semantics: data_valid, parity_error and framing_error are each a
  // single-cycle pulse, mutually exclusive, raised the cycle after the stop
  // sample; there is no back-pressure, so a pulse must be consumed when seen.
  always_comb begin
    shift_d         = shift_q;
    bit_idx_d       = bit_idx_q;
    par_d           = par_q;
    out_data_d      = out_data_q;
    data_valid_d    = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      RX_IDLE: bit_idx_d = '0;
      RX_DATA: if (tick) begin
        shift_d[bit_idx_q] = serial_in;
        bit_idx_d          = bit_idx_q + IDX_W'(1);
      end
      RX_PARITY: if (tick) par_d = serial_in;
      RX_STOP: if (tick) begin
        if (!serial_in)             framing_error_d = 1'b1;
        else if (^{shift_q, par_q}) parity_error_d  = 1'b1;
        else begin
          data_valid_d = 1'b1;
          out_data_d   = shift_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q         <= '0;
      bit_idx_q       <= '0;
      par_q           <= 1'b0;
      out_data_q      <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      shift_q         <= shift_d;
      bit_idx_q       <= bit_idx_d;
      par_q           <= par_d;
      out_data_q      <= out_data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((parity_error_d || framing_error_d) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  always_comb begin
    out_data      = out_data_q;
    data_valid    = data_valid_q;
    parity_error  = parity_error_q;
    framing_error = framing_error_q;
    busy          = (state_q != RX_IDLE) | data_valid_q | parity_error_q | framing_error_q;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_serial_data_receiver.sv
// Bench for serial_data_receiver: one instance at 1 clk/bit, one at 4 clk/bit,
// random framed traffic against a frame-level model and an expected-strobe queue.
module tb_serial_data_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser1, ser4;
  logic [6:0] od1, od4;
  logic       dv1, pe1, fe1, bsy1;
  logic       dv4, pe4, fe4, bsy4;
  logic [2:0] st1, st4;
`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0] err1, err4;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] exp_q1[$];
  logic [8:0] exp_q4[$];
  int         exp_t1[$];
  int         exp_t4[$];
  logic [6:0] last_good[2];
  int         err_model[2];

  serial_data_receiver #(.DATA_W(7), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .serial_in(ser1), .out_data(od1), .data_valid(dv1),
    .parity_error(pe1), .framing_error(fe1), .busy(bsy1), .state_dbg(st1)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_count(err1)
`endif
  );

  serial_data_receiver #(.DATA_W(7), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .serial_in(ser4), .out_data(od4), .data_valid(dv4),
    .parity_error(pe4), .framing_error(fe4), .busy(bsy4), .state_dbg(st4)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_count(err4)
`endif
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int cpb(input int id);
    return (id == 0) ? 1 : 4;
  endfunction

  // monitor: pop and compare whenever a strobe appears
  task automatic observe(input int id, input logic dv, input logic pe, input logic fe,
                         input logic [6:0] od);
    logic [8:0] e;
    int         et;
    logic [1:0] k;
    bit         empty;
    check("strobe_exclusive", 32'(int'(dv) + int'(pe) + int'(fe)), 32'd1);
    k = dv ? 2'd1 : (pe ? 2'd2 : 2'd3);
    empty = (id == 0) ? (exp_q1.size() == 0) : (exp_q4.size() == 0);
    if (empty) begin
      total++;
      bad++;
      $display("FAIL unexpected_strobe dut=%0d actual kind=%0d data=%0h required=none", id, k, od);
    end else begin
      if (id == 0) begin e = exp_q1.pop_front(); et = exp_t1.pop_front(); end
      else         begin e = exp_q4.pop_front(); et = exp_t4.pop_front(); end
      check((id == 0) ? "strobe_kind_data_1" : "strobe_kind_data_4", 32'({k, od}), 32'(e));
      check((id == 0) ? "strobe_cycle_1" : "strobe_cycle_4", 32'(cyc), 32'(et));
    end
  endtask

  always @(negedge clk) if (dv1 | pe1 | fe1) observe(0, dv1, pe1, fe1, od1);
  always @(negedge clk) if (dv4 | pe4 | fe4) observe(1, dv4, pe4, fe4, od4);

  // drivers: every task starts and ends 1 time unit after a rising edge
  task automatic drive_bit(input int id, input logic b, input int n);
    if (id == 0) ser1 = b;
    else         ser4 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0 good, 1 wrong parity, 2 stop bit low (line then held low low_after cycles)
  task automatic send_frame(input int id, input logic [6:0] d, input int mode, input int low_after);
    logic [9:0] fr;
    int         c, h, kind;
    c      = cpb(id);
    h      = (c - 1) / 2;
    fr[0]  = 1'b0;
    fr[7:1] = d;
    fr[8]  = (^d) ^ (mode == 1);
    fr[9]  = (mode != 2);
    if (!fr[9])          kind = 3;
    else if (^fr[8:1])   kind = 2;
    else                 kind = 1;
    if (kind == 1) last_good[id] = d;
    else if (err_model[id] < 255) err_model[id]++;
    if (id == 0) begin
      exp_q1.push_back({2'(kind), last_good[id]});
      exp_t1.push_back(cyc + 1 + h + 9 * c);
    end else begin
      exp_q4.push_back({2'(kind), last_good[id]});
      exp_t4.push_back(cyc + 1 + h + 9 * c);
    end
    for (int k = 0; k < 10; k++) drive_bit(id, fr[k], c);
    if (!fr[9]) begin
      for (int i = 0; i < low_after; i++) begin
        drive_bit(id, 1'b0, 1);
        check("busy_in_break", 32'((id == 0) ? bsy1 : bsy4), 32'd1);
      end
      drive_bit(id, 1'b1, 2);
    end
  endtask

  task automatic random_frames(input int id, input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 3);
      send_frame(id, 7'($urandom_range(0, 127)), (r < 2) ? 0 : r - 1, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) drive_bit(id, 1'b1, $urandom_range(1, 3));
    end
  endtask

  initial begin
    ser1 = 1'b1;
    ser4 = 1'b1;
    last_good[0] = '0; last_good[1] = '0;
    err_model[0] = 0;  err_model[1] = 0;

    // reset with the lines toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ser1 = ~ser1;
      ser4 = ~ser4;
    end
    @(posedge clk); #1;
    check("reset_outputs_1", 32'({od1, dv1, pe1, fe1, bsy1}), 32'd0);
    check("reset_outputs_4", 32'({od4, dv4, pe4, fe4, bsy4}), 32'd0);
    ser1 = 1'b1;
    ser4 = 1'b1;
    rst  = 1'b0;
    drive_bit(0, 1'b1, 3);
    check("idle_busy_1", 32'(bsy1), 32'd0);

    // directed frames at one clock per bit
    send_frame(0, 7'b0010011, 0, 0);
    send_frame(0, 7'b1111110, 0, 0);
    send_frame(0, 7'h55, 0, 0);
    send_frame(0, 7'b0010011, 1, 0);
    send_frame(0, 7'h2a, 2, 20);
    send_frame(0, 7'h41, 0, 0);
    check("out_data_hold_1", 32'(od1), 32'h41);
    random_frames(0, 40);

    // reset in the middle of a frame: partial word is dropped silently
    drive_bit(0, 1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'($urandom_range(0, 1)), 1);
    rst  = 1'b1;
    ser1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midframe_reset_1", 32'({od1, dv1, pe1, fe1, bsy1}), 32'd0);
    last_good[0] = '0; last_good[1] = '0;
    err_model[0] = 0;  err_model[1] = 0;
    drive_bit(0, 1'b1, 3);

    // four clocks per bit: a one-cycle glitch is a false start
    drive_bit(1, 1'b0, 1);
    drive_bit(1, 1'b1, 6);
    check("false_start_busy_4", 32'(bsy4), 32'd0);
    send_frame(1, 7'b0010011, 0, 0);
    random_frames(1, 30);

`ifdef SERIAL_RX_ERR_CNT_EN
    for (int i = 0; i < 300; i++) send_frame(0, 7'($urandom_range(0, 127)), 1 + (i % 2), 1);
    check("err_count_sat_1", 32'(err1), 32'(err_model[0]));
    check("err_count_4", 32'(err4), 32'(err_model[1]));
`endif

    drive_bit(0, 1'b1, 10);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    check("exp_q4_drained", 32'(exp_q4.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
